// File: rtl/capture_ram.sv
// capture_ram: result-capture buffer on the output side of the transposed FIR.
//
// Filtered samples arrive on in_data/in_valid. While the block is capturing,
// each sample is written into an internal RAM at consecutive locations. An
// Avalon-MM host starts and clears capture through a 4-word CSR window at
// CSR_BASE. It reads the captured samples back through a buffer window at
// BUF_BASE.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   address        Avalon-MM word address (18 bits)
//   write          Avalon write strobe
//   writedata      Avalon write data
//   read           Avalon read strobe
//   readdata       read data, valid while readdatavalid=1, held otherwise
//   readdatavalid  one-cycle pulse, one cycle after an accepted read
//   in_data        filtered sample from the FIR
//   in_valid       sample strobe, at most one sample per cycle
//   busy           high while capturing
//   done           high once the capture length is reached, until start/clear
//
// CSR map (offset from CSR_BASE):
//   0 CTRL   (W) bit0 start, bit1 clear; reads as 0
//   1 STATUS (R) bit0 busy, bit1 done, bit2 overflow
//   2 COUNT  (R) samples captured
//   3 LIMIT  (R/W) capture length; 0 or >DEPTH stores DEPTH

module capture_ram #(
    parameter int unsigned DEPTH    = 2048,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned CSR_BASE = 12288,
    parameter int unsigned BUF_BASE = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [17:0]       address,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    input  logic              read,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              busy,
    output logic              done
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [17:0] CSR_LO  = 18'(CSR_BASE);
    localparam logic [17:0] BUF_LO  = 18'(BUF_BASE);
    localparam logic [17:0] BUF_HI  = 18'(BUF_BASE + DEPTH);
    localparam logic [15:0] DEPTH_V = 16'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   wr_ptr, wr_ptr_nxt;
    logic [15:0]     count, count_nxt;
    logic [15:0]     limit, limit_wval;
    logic            overflow, overflow_nxt;
    logic            ram_we;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] csr_val, csr_q;
    logic              rd_sel_buf;

    // ---------------- address decode ----------------
    logic is_ctrl, is_status, is_count, is_limit, in_buf;
    logic [AW-1:0] buf_idx;
    logic rd_acc, start, clear, limit_we;

    assign is_ctrl   = (address == CSR_LO);
    assign is_status = (address == CSR_LO + 18'd1);
    assign is_count  = (address == CSR_LO + 18'd2);
    assign is_limit  = (address == CSR_LO + 18'd3);
    assign in_buf    = (address >= BUF_LO) && (address < BUF_HI);
    assign buf_idx   = AW'(address - BUF_LO);

    // A read that coincides with a write is dropped; the write takes the bus.
    assign rd_acc   = read && !write;
    assign clear    = write && is_ctrl && writedata[1];
    assign start    = write && is_ctrl && writedata[0] && !writedata[1];
    assign limit_we = write && is_limit && (state != CAPTURE);

    always_comb begin
        limit_wval = 16'(writedata);
        if ((limit_wval == 16'd0) || (limit_wval > DEPTH_V)) begin
            limit_wval = DEPTH_V;
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            limit    <= DEPTH_V;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            count    <= count_nxt;
            overflow <= overflow_nxt;
            if (limit_we) begin
                limit <= limit_wval;
            end
        end
    end

    // Clear overrides start. Start overrides the current state's sample
    // handling, so a sample that arrives in the same cycle as start is
    // dropped.
    always_comb begin
        state_nxt    = state;
        wr_ptr_nxt   = wr_ptr;
        count_nxt    = count;
        overflow_nxt = overflow;
        ram_we       = 1'b0;
        if (clear) begin
            state_nxt    = IDLE;
            wr_ptr_nxt   = '0;
            count_nxt    = '0;
            overflow_nxt = 1'b0;
        end else if (start) begin
            state_nxt    = CAPTURE;
            wr_ptr_nxt   = '0;
            count_nxt    = '0;
            overflow_nxt = 1'b0;
        end else begin
            case (state)
                CAPTURE: begin
                    if (in_valid) begin
                        ram_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + AW'(1);
                        count_nxt  = count + 16'd1;
                        if (count + 16'd1 == limit) begin
                            state_nxt = DONE;
                        end
                    end
                end
                DONE: begin
                    if (in_valid) begin
                        overflow_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == CAPTURE);
    assign done = (state == DONE);

    // ---------------- sample RAM ----------------
    // One write port for the stream and one synchronous read port for the
    // bus. The RAM is not reset. A same-edge read of the location being
    // written returns the old data.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[wr_ptr] <= in_data;
        end
        if (rd_acc && in_buf) begin
            ram_q <= mem[buf_idx];
        end
    end

    // ---------------- read path ----------------
    always_comb begin
        csr_val = '0;
        if (is_status) begin
            csr_val = DATA_W'({overflow, done, busy});
        end else if (is_count) begin
            csr_val = DATA_W'(count);
        end else if (is_limit) begin
            csr_val = DATA_W'(limit);
        end
    end

    // readdata is a mux of two registers. Each register updates only on an
    // accepted read of its own kind, so readdata holds between reads. Only
    // the select and the CSR register need a reset to give readdata=0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdatavalid <= 1'b0;
            rd_sel_buf    <= 1'b0;
            csr_q         <= '0;
        end else begin
            readdatavalid <= rd_acc;
            if (rd_acc) begin
                rd_sel_buf <= in_buf;
                if (!in_buf) begin
                    csr_q <= csr_val;
                end
            end
        end
    end

    assign readdata = rd_sel_buf ? ram_q : csr_q;

endmodule

// File: tb/tb_capture_ram.sv
// Directed testbench for capture_ram. All expected values are hand-computed
// from the block's register map and capture rules.

module tb_capture_ram;

    localparam logic [17:0] A_CTRL   = 18'h3000;
    localparam logic [17:0] A_STATUS = 18'h3001;
    localparam logic [17:0] A_COUNT  = 18'h3002;
    localparam logic [17:0] A_LIMIT  = 18'h3003;
    localparam logic [17:0] A_BUF    = 18'h4000;

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] address;
    logic        write;
    logic [15:0] writedata;
    logic        read;
    logic [15:0] readdata;
    logic        readdatavalid;
    logic [15:0] in_data;
    logic        in_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    capture_ram #(
        .DEPTH    (2048),
        .DATA_W   (16),
        .CSR_BASE (12288),
        .BUF_BASE (16384)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .write         (write),
        .writedata     (writedata),
        .read          (read),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [17:0] a, input logic [15:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
    endtask

    // One read: the data and the valid pulse appear after the accepting
    // edge, and the valid pulse drops one cycle later.
    task automatic rd(input logic [17:0] a, input logic [15:0] exp, input string tag);
        address = a;
        read    = 1'b1;
        tick();
        read    = 1'b0;
        chk({tag, "_valid"}, 32'(readdatavalid), 32'd1);
        chk(tag, 32'(readdata), 32'(exp));
        tick();
        chk({tag, "_pulse"}, 32'(readdatavalid), 32'd0);
    endtask

    task automatic sample(input logic [15:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp4 [4];
        exp4[0] = 16'h0011; exp4[1] = 16'h0022; exp4[2] = 16'h0033; exp4[3] = 16'h0044;

        reset = 1'b0; address = '0; write = 1'b0; writedata = '0;
        read = 1'b0; in_data = '0; in_valid = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdv", 32'(readdatavalid), 32'd0);
        chk("rst_rdata", 32'(readdata), 32'd0);
        reset = 1'b1;
        tick();

        rd(A_STATUS, 16'h0000, "status_rst");
        rd(A_COUNT,  16'h0000, "count_rst");
        rd(A_LIMIT,  16'h0800, "limit_rst");

        // Preload location 4 with a known value, then clear.
        wr(A_CTRL, 16'h0001);
        chk("busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) sample(16'h00A0 + 16'(i));
        rd(A_COUNT, 16'd5, "count_pre");
        wr(A_CTRL, 16'h0002);
        chk("busy_clear", 32'(busy), 32'd0);
        rd(A_COUNT, 16'd0, "count_clear");

        // LIMIT=4 capture with gaps in in_valid.
        wr(A_LIMIT, 16'd4);
        wr(A_CTRL, 16'h0001);
        sample(16'h0011); tick();
        sample(16'h0022); tick(); tick();
        sample(16'h0033);
        chk("done_before", 32'(done), 32'd0);
        sample(16'h0044);
        chk("done_4th", 32'(done), 32'd1);
        chk("busy_4th", 32'(busy), 32'd0);
        rd(A_COUNT, 16'd4, "count_4");

        // Back-to-back buffer reads: one result per cycle.
        read = 1'b1;
        address = A_BUF;
        tick();
        for (int i = 0; i < 4; i++) begin
            address = A_BUF + 18'(i + 1);
            if (i == 3) read = 1'b0;
            chk("b2b_valid", 32'(readdatavalid), 32'd1);
            chk("b2b_data", 32'(readdata), 32'(exp4[i]));
            if (i < 3) tick();
        end
        tick();
        chk("b2b_end", 32'(readdatavalid), 32'd0);
        chk("hold_data", 32'(readdata), 32'h0044);

        // A sample in DONE sets overflow and is not written.
        sample(16'h7FFF);
        rd(A_STATUS, 16'h0006, "status_ovf");
        rd(A_BUF + 18'd4, 16'h00A4, "loc4_kept");
        rd(A_COUNT, 16'd4, "count_ovf");
        wr(A_BUF + 18'd4, 16'hBEEF);
        rd(A_BUF + 18'd4, 16'h00A4, "buf_wr_ign");
        rd(A_CTRL, 16'h0000, "ctrl_reads0");

        // LIMIT saturation.
        wr(A_LIMIT, 16'd0);
        rd(A_LIMIT, 16'h0800, "limit_0");
        wr(A_LIMIT, 16'd5000);
        rd(A_LIMIT, 16'h0800, "limit_5000");
        wr(A_LIMIT, 16'd4);
        wr(A_CTRL, 16'h0001);
        rd(A_STATUS, 16'h0001, "status_cap");
        wr(A_LIMIT, 16'd3);
        rd(A_LIMIT, 16'd4, "limit_ign");

        // Start coincident with a sample: the sample is dropped.
        address = A_CTRL; writedata = 16'h0001; write = 1'b1;
        in_data = 16'h1234; in_valid = 1'b1;
        tick();
        write = 1'b0; in_valid = 1'b0;
        rd(A_COUNT, 16'd0, "count_coinc");
        sample(16'h5555);
        rd(A_BUF, 16'h5555, "buf0_next");
        rd(A_COUNT, 16'd1, "count_next");
        wr(A_CTRL, 16'h0003);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_done", 32'(done), 32'd0);
        rd(A_STATUS, 16'h0000, "status_clr");

        // Read and write together: the write happens and there is no read pulse.
        address = A_LIMIT; writedata = 16'd7; write = 1'b1; read = 1'b1;
        tick();
        write = 1'b0; read = 1'b0;
        chk("rw_novalid", 32'(readdatavalid), 32'd0);
        rd(A_LIMIT, 16'd7, "limit_rw");

        // Reset in the middle of a capture.
        wr(A_LIMIT, 16'd0);
        wr(A_CTRL, 16'h0001);
        for (int i = 0; i < 10; i++) sample(16'h0100 + 16'(i));
        rd(A_COUNT, 16'd10, "count_10");
        #2;
        reset = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_rdata", 32'(readdata), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        rd(A_COUNT, 16'd0, "count_after_rst");
        rd(A_LIMIT, 16'h0800, "limit_after_rst");
        rd(18'h5FFF, 16'h0000, "out_of_window");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
